program_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle MIPS datapath. It receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them sequentially into the instruction memory's write port. It holds the CPU in reset until the full program has been written, then releases it so that fetch starts at PC 0.

---
 rtl/program_loader_if.sv | 22 ++
 rtl/program_loader.sv | 119 +++++++++++
 tb/tb_program_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Latency: none, wires only.
// Backpressure: byte_ready is driven by the loader; the write port has no ready and is never stalled.
interface program_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  // master: the system side (byte source plus instruction memory); slave: the loader
  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: turns a big-endian byte stream into 32-bit instruction writes, then releases CPU reset.
// Latency: 4th byte of a word accepted -> imem_we next cycle; last write -> done/cpu_reset low next cycle.
// Backpressure: byte_ready only in LEN_HI/LEN_LO/LOAD; gaps in byte_valid stall in place with no timeout.
module program_loader #(
  parameter int MEM_WORDS = 128,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] LOAD   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  localparam logic [CNT_W-1:0] maxLen = CNT_W'(MEM_WORDS);

  logic [2:0]       state;
  logic [2:0]       stateNext;
  logic [7:0]       lenHi;
  logic [CNT_W-1:0] progLen;
  logic [CNT_W-1:0] lenFull;
  logic [31:0]      wordReg;
  logic [31:0]      nextWord;
  logic [1:0]       byteIdx;
  logic             accept;
  logic             startLoad;
  logic             lastWord;
  logic             weReg;
  logic [31:0]      addrReg;
  logic [31:0]      dataReg;

  // byte_ready is the only output decoded straight from state
  assign bus.byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == LOAD);
  assign bus.imem_we    = weReg;
  assign bus.imem_addr  = addrReg;
  assign bus.imem_wdata = dataReg;

  assign accept    = bus.byte_valid && bus.byte_ready;
  // start is honoured only when no load is in flight
  assign startLoad = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign lenFull   = CNT_W'({lenHi, bus.byte_in});
  assign nextWord  = {wordReg[23:0], bus.byte_in};
  assign lastWord  = (word_count + CNT_W'(1)) == progLen;

  // Next-state decode of the load sequence
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (startLoad) stateNext = LEN_HI;
      LEN_HI: if (accept) stateNext = LEN_LO;
      LEN_LO: if (accept) stateNext = ((lenFull == '0) || (lenFull > maxLen)) ? ERROR : LOAD;
      LOAD:   if (accept && (byteIdx == 2'd3)) stateNext = WRITE;
      WRITE:  stateNext = lastWord ? DONE : LOAD;
      DONE:   if (startLoad) stateNext = LEN_HI;
      ERROR:  if (startLoad) stateNext = LEN_HI;
      default: stateNext = IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs are computed from the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lenHi      <= '0;
      progLen    <= '0;
      wordReg    <= '0;
      byteIdx    <= '0;
      word_count <= '0;
      weReg      <= 1'b0;
      addrReg    <= '0;
      dataReg    <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state     <= stateNext;
      busy      <= (stateNext == LEN_HI) || (stateNext == LEN_LO) ||
                   (stateNext == LOAD)   || (stateNext == WRITE);
      cpu_reset <= (stateNext != DONE);
      done      <= (stateNext == DONE);
      error     <= (stateNext == ERROR);
      weReg     <= (stateNext == WRITE);

      if ((state == LEN_HI) && accept) lenHi <= bus.byte_in;
      if ((state == LEN_LO) && accept) progLen <= lenFull;

      if ((state == LOAD) && accept) begin
        wordReg <= nextWord;
        byteIdx <= byteIdx + 2'd1;
        if (byteIdx == 2'd3) begin
          // address and data are captured with the final byte so they are stable during WRITE
          addrReg <= 32'({word_count, 2'b00});
          dataReg <= nextWord;
        end
      end

      if (state == WRITE) word_count <= word_count + CNT_W'(1);

      if (startLoad) begin
        word_count <= '0;
        byteIdx    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: streams programs, scoreboards writes against a word-list model.
// Latency: checks start->busy, last write->done timing.
// Backpressure: random byte_valid gaps with random byte_in while idle.
module tb_program_loader;
  localparam int MEM_WORDS = 128;
  localparam int CNT_W     = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic             cpu_reset;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] word_count;

  program_loader_if busIf ();

  program_loader #(.MEM_WORDS(MEM_WORDS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (busIf),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  logic [63:0] gotQ[$];
  int weDouble;
  int readyInWrite;
  int oobCount;
  int lastWeCycle;
  int doneRiseCycle;
  int cpuFallCycle;
  logic prevWe;
  logic prevDone;
  logic prevCpu;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Write-port monitor, sampled mid-cycle
  initial begin
    prevWe = 1'b0; prevDone = 1'b0; prevCpu = 1'b1;
    weDouble = 0; readyInWrite = 0; oobCount = 0;
    lastWeCycle = -1; doneRiseCycle = -1; cpuFallCycle = -1;
    forever begin
      @(negedge clk);
      if (busIf.imem_we === 1'b1) begin
        gotQ.push_back({busIf.imem_addr, busIf.imem_wdata});
        lastWeCycle = cyc;
        if (prevWe) weDouble++;
        if (busIf.byte_ready) readyInWrite++;
        if (busIf.imem_addr >= 32'(4 * MEM_WORDS)) oobCount++;
      end
      if (done && !prevDone) doneRiseCycle = cyc;
      if (!cpu_reset && prevCpu) cpuFallCycle = cyc;
      prevWe   = busIf.imem_we;
      prevDone = done;
      prevCpu  = cpu_reset;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkResetVals(input string pfx);
    checkVal({pfx, "_byte_ready"}, 32'(busIf.byte_ready), 32'd0);
    checkVal({pfx, "_imem_we"}, 32'(busIf.imem_we), 32'd0);
    checkVal({pfx, "_imem_addr"}, busIf.imem_addr, 32'd0);
    checkVal({pfx, "_imem_wdata"}, busIf.imem_wdata, 32'd0);
    checkVal({pfx, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    checkVal({pfx, "_busy"}, 32'(busy), 32'd0);
    checkVal({pfx, "_done"}, 32'(done), 32'd0);
    checkVal({pfx, "_error"}, 32'(error), 32'd0);
    checkVal({pfx, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  // Pulse start for one clock; returns just after the edge that captured it
  task automatic pulseStart();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Call just after a rising edge; returns just after the edge that accepted the byte
  task automatic sendByte(input logic [7:0] b, input int gap);
    int budget;
    logic acc;
    repeat (gap) begin
      busIf.byte_valid = 1'b0;
      busIf.byte_in    = 8'($urandom);
      @(posedge clk); #1;
    end
    busIf.byte_in    = b;
    busIf.byte_valid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      acc = busIf.byte_ready;
      @(posedge clk); #1;
      if (acc) break;
      budget++;
      if (budget > 50) begin
        checkVal("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    busIf.byte_valid = 1'b0;
    busIf.byte_in    = 8'($urandom);
  endtask

  // Model: a legal length yields writes (4*i, word[i]) for every word, else only error
  task automatic runLoad(input int n, input int gapMin, input int gapMax, input int dataMode);
    logic [31:0] words[$];
    logic [7:0]  stream[$];
    logic [15:0] n16;
    logic [31:0] w;
    bit legal;
    int budget;
    n16   = 16'(n);
    legal = (n >= 1) && (n <= MEM_WORDS);
    stream.push_back(n16[15:8]);
    stream.push_back(n16[7:0]);
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        if (dataMode == 1)      w = 32'(i);
        else if (dataMode == 2) w = (i == 0) ? 32'h2008_0005 : 32'h8C09_0004;
        else                    w = $urandom;
        words.push_back(w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
      end
    end

    gotQ.delete();
    weDouble = 0; readyInWrite = 0; oobCount = 0;
    doneRiseCycle = -1; cpuFallCycle = -1; lastWeCycle = -1;

    pulseStart();
    @(negedge clk);
    checkVal("start_busy", 32'(busy), 32'd1);
    checkVal("start_byte_ready", 32'(busIf.byte_ready), 32'd1);
    checkVal("start_cpu_reset", 32'(cpu_reset), 32'd1);
    checkVal("start_done", 32'(done), 32'd0);
    checkVal("start_error", 32'(error), 32'd0);
    checkVal("start_word_count", 32'(word_count), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < stream.size(); i++)
      sendByte(stream[i], $urandom_range(gapMax, gapMin));

    budget = 0;
    forever begin
      @(negedge clk);
      if (done || error) break;
      budget++;
      if (budget > 20) begin
        checkVal("finish_timeout", 32'd0, 32'd1);
        break;
      end
    end

    checkVal("end_done", 32'(done), 32'(legal));
    checkVal("end_error", 32'(error), 32'(!legal));
    checkVal("end_cpu_reset", 32'(cpu_reset), 32'(!legal));
    checkVal("end_byte_ready", 32'(busIf.byte_ready), 32'd0);
    checkVal("end_busy", 32'(busy), 32'd0);
    checkVal("end_word_count", 32'(word_count), legal ? 32'(n) : 32'd0);
    checkVal("write_count", 32'(gotQ.size()), 32'(words.size()));
    for (int i = 0; i < gotQ.size() && i < words.size(); i++) begin
      checkVal("write_addr", gotQ[i][63:32], 32'(4 * i));
      checkVal("write_data", gotQ[i][31:0], words[i]);
    end
    checkVal("we_multi_cycle", 32'(weDouble), 32'd0);
    checkVal("ready_in_write", 32'(readyInWrite), 32'd0);
    checkVal("write_out_of_range", 32'(oobCount), 32'd0);
    if (legal) begin
      checkVal("done_after_last_we", 32'(doneRiseCycle - lastWeCycle), 32'd1);
      checkVal("cpu_release_after_last_we", 32'(cpuFallCycle - lastWeCycle), 32'd1);
    end
  endtask

  // Reset lands after byte 2 of word 1; word 0 must survive, word 1 must never be written
  task automatic midLoadReset();
    gotQ.delete();
    pulseStart();
    @(posedge clk); #1;
    sendByte(8'h00, 0);
    sendByte(8'h02, 0);
    sendByte(8'hDE, 1);
    sendByte(8'hAD, 0);
    sendByte(8'hBE, 2);
    sendByte(8'hEF, 0);
    sendByte(8'h12, 1);
    sendByte(8'h34, 0);
    #2;
    reset = 1'b1;
    #1;
    checkResetVals("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkVal("midrst_write_count", 32'(gotQ.size()), 32'd1);
    if (gotQ.size() > 0) begin
      checkVal("midrst_w0_addr", gotQ[0][63:32], 32'd0);
      checkVal("midrst_w0_data", gotQ[0][31:0], 32'hDEAD_BEEF);
    end
    checkVal("midrst_idle_word_count", 32'(word_count), 32'd0);
  endtask

  initial begin
    reset            = 1'b1;
    start            = 1'b0;
    busIf.byte_valid = 1'b0;
    busIf.byte_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetVals("rst");

    runLoad(2, 0, 0, 2);
    runLoad(2, 3, 3, 2);
    runLoad(0, 0, 1, 0);
    runLoad(129, 0, 1, 0);
    runLoad(256, 0, 0, 0);
    runLoad(128, 0, 0, 1);
    for (int k = 0; k < 5; k++)
      runLoad($urandom_range(12, 1), 0, 2, 0);
    midLoadReset();
    runLoad(3, 0, 1, 0);
    runLoad(2, 0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
